// File: rtl/UART_pkg.sv
// Shared UART definitions: byte width and the TX arbiter's sequencing states.
package UART_pkg;

   localparam int DATA_WIDTH = 8;

   typedef enum logic [1:0] {
      ARB_IDLE,
      ARB_LAUNCH,
      ARB_WAIT_BUSY,
      ARB_WAIT_DONE
   } tx_arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_rr_select.sv
// Rotating-priority picker: first set request at or after ptr, wrapping modulo NUM_REQ.
module rr_select #(
   parameter  int NUM_REQ = 4,
   localparam int IW      = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IW-1:0]      ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IW-1:0]      idx,
   output logic               any
);

   int j;

   assign any = |req;

   // Walk offsets from farthest to nearest so the nearest set request is written last.
   always_comb begin
      grant = '0;
      idx   = '0;
      j     = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         j = (int'(ptr) + i) % NUM_REQ;
         if (req[j]) begin
            grant    = '0;
            grant[j] = 1'b1;
            idx      = IW'(j);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between NUM_REQ byte producers, one full frame per grant.
// Define UART_TX_ARB_TIMEOUT_EN to abandon a launch the transmitter never acknowledges.
module uart_tx_arbiter #(
   parameter  int NUM_REQ        = 4,
   parameter  int DATA_WIDTH     = UART_pkg::DATA_WIDTH,
   parameter  int TIMEOUT_CYCLES = 16,
   localparam int IW             = $clog2(NUM_REQ)
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   output logic [DATA_WIDTH-1:0]         tx_p_data,
   output logic                          tx_data_valid,
   input  logic                          tx_busy,
   output logic [IW-1:0]                 grant_id,
   output logic                          arb_busy,
   output logic                          tx_timeout
);
   import UART_pkg::*;

   tx_arb_state_e                      state;
   logic [IW-1:0]                      ptr;
   logic [IW-1:0]                      next_ptr;
   logic [IW-1:0]                      sel_idx;
   logic [NUM_REQ-1:0]                 sel_oh;
   logic                               sel_any;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_bytes;
   logic                               timed_out;

   assign req_bytes = req_data;
   assign arb_busy  = (state != ARB_IDLE);
   assign next_ptr  = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;

   rr_select #(.NUM_REQ(NUM_REQ)) u_rr_select (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (sel_oh),
      .idx   (sel_idx),
      .any   (sel_any)
   );

`ifdef UART_TX_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wait_cnt;

   assign timed_out = !tx_busy && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

   // Counts WAIT_BUSY cycles; the flag stays up until reset so software can see it happened.
   always_ff @(posedge CLK) begin
      if (RST) begin
         wait_cnt   <= '0;
         tx_timeout <= 1'b0;
      end else if (state != ARB_WAIT_BUSY) begin
         wait_cnt <= '0;
      end else begin
         wait_cnt <= wait_cnt + 1'b1;
         if (timed_out) tx_timeout <= 1'b1;
      end
   end
`else
   assign timed_out  = 1'b0;
   assign tx_timeout = 1'b0;
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state         <= ARB_IDLE;
         ptr           <= '0;
         req_ready     <= '0;
         tx_p_data     <= '0;
         tx_data_valid <= 1'b0;
         grant_id      <= '0;
      end else begin
         req_ready     <= '0;
         tx_data_valid <= 1'b0;
         unique case (state)
            // A frame still in flight from before reset keeps us here until it ends.
            ARB_IDLE: begin
               if (!tx_busy && sel_any) begin
                  req_ready <= sel_oh;
                  tx_p_data <= req_bytes[sel_idx];
                  grant_id  <= sel_idx;
                  state     <= ARB_LAUNCH;
               end
            end
            ARB_LAUNCH: begin
               tx_data_valid <= 1'b1;
               state         <= ARB_WAIT_BUSY;
            end
            ARB_WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= ARB_WAIT_DONE;
               end else if (timed_out) begin
                  ptr   <= next_ptr;
                  state <= ARB_IDLE;
               end
            end
            ARB_WAIT_DONE: begin
               if (!tx_busy) begin
                  ptr   <= next_ptr;
                  state <= ARB_IDLE;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized and directed bench for uart_tx_arbiter against a transaction-level reference model.
module tb_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int TO = 16;
   localparam int IW = $clog2(N);

   logic          CLK = 1'b0;
   logic          RST = 1'b1;
   logic [N-1:0]  req_valid = '0;
   logic [N*DW-1:0] req_data = '0;
   logic [N-1:0]  req_ready;
   logic [DW-1:0] tx_p_data;
   logic          tx_data_valid;
   logic          tx_busy = 1'b0;
   logic [IW-1:0] grant_id;
   logic          arb_busy;
   logic          tx_timeout;

   uart_tx_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
      .CLK           (CLK),
      .RST           (RST),
      .req_valid     (req_valid),
      .req_data      (req_data),
      .req_ready     (req_ready),
      .tx_p_data     (tx_p_data),
      .tx_data_valid (tx_data_valid),
      .tx_busy       (tx_busy),
      .grant_id      (grant_id),
      .arb_busy      (arb_busy),
      .tx_timeout    (tx_timeout)
   );

   always #5 CLK = ~CLK;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transmitter stand-in: a launch pulse starts a frame of frame_len busy cycles.
   int busy_cnt  = 0;
   int frame_len = 11;
   bit tx_auto   = 1'b1;
   bit tx_force  = 1'b0;
   always @(negedge CLK) begin
      if (busy_cnt > 0) busy_cnt--;
      if (tx_data_valid && tx_auto) busy_cnt = frame_len;
      tx_busy = (busy_cnt > 0) || tx_force;
   end

   // Inputs as seen by the DUT at each rising edge.
   logic            s_rst, s_busy;
   logic [N-1:0]    s_valid;
   logic [N*DW-1:0] s_data;
   always @(posedge CLK) begin
      s_rst   <= RST;
      s_busy  <= tx_busy;
      s_valid <= req_valid;
      s_data  <= req_data;
   end

   // Reference model: owner<0 means the transmitter is free for arbitration.
   int            owner = -1, phase = 0, ptr = 0, waited = 0, exp_gid = 0;
   logic [N-1:0]  exp_ready = '0;
   logic [DW-1:0] exp_data = '0;
   bit            exp_dv = 1'b0, exp_to = 1'b0, started = 1'b0;
   int            grant_log[$];
   logic [DW-1:0] tx_log[$];

   function automatic int pick(input logic [N-1:0] v, input int p);
      for (int i = 0; i < N; i++)
         if (v[(p + i) % N]) return (p + i) % N;
      return -1;
   endfunction

   always @(negedge CLK) begin : compare
      int k;
      exp_ready = '0;
      exp_dv    = 1'b0;
      if (s_rst) begin
         started = 1'b1; owner = -1; phase = 0; ptr = 0;
         exp_data = '0; exp_gid = 0; exp_to = 1'b0;
      end else if (owner < 0) begin
         k = pick(s_valid, ptr);
         if (!s_busy && k >= 0) begin
            owner = k; phase = 1; exp_gid = k;
            exp_ready[k] = 1'b1;
            exp_data = s_data[k*DW +: DW];
            grant_log.push_back(k);
         end
      end else if (phase == 1) begin
         exp_dv = 1'b1; phase = 2; waited = 0;
      end else if (phase == 2) begin
         if (s_busy) phase = 3;
`ifdef UART_TX_ARB_TIMEOUT_EN
         else begin
            waited++;
            if (waited == TO) begin exp_to = 1'b1; ptr = (owner + 1) % N; owner = -1; end
         end
`endif
      end else if (!s_busy) begin
         ptr = (owner + 1) % N; owner = -1;
      end

      if (started) begin
         check("req_ready",     32'(req_ready),     32'(exp_ready));
         check("tx_data_valid", 32'(tx_data_valid), 32'(exp_dv));
         check("tx_p_data",     32'(tx_p_data),     32'(exp_data));
         check("grant_id",      32'(grant_id),      32'(exp_gid));
         check("arb_busy",      32'(arb_busy),      32'(owner >= 0));
         check("tx_timeout",    32'(tx_timeout),    32'(exp_to));
         if (tx_data_valid) tx_log.push_back(tx_p_data);
      end
   end

   task automatic tick();
      @(negedge CLK);
      #1;
   endtask

   task automatic reset_pulse();
      RST = 1'b1; tick(); tick(); RST = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int c = 0;
      while ((arb_busy || tx_busy) && c < budget) begin tick(); c++; end
      check("idle_within_budget", 32'(c < budget), 32'd1);
   endtask

   task automatic run_frames(input logic [N-1:0] v, input int n);
      int target = grant_log.size() + n;
      int c = 0;
      req_valid = v;
      while (grant_log.size() < target && c < 400) begin tick(); c++; end
      check("grants_within_budget", 32'(grant_log.size() >= target), 32'd1);
      req_valid = '0;
      wait_idle(100);
   endtask

   initial begin
      int c, pulses;
      int order2[5] = '{0, 1, 2, 3, 0};
      int order3[3] = '{3, 0, 3};

      tick(); tick();
      check("rst_arb_busy", 32'(arb_busy), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      RST = 1'b0;

      // Single requester: accept pulse next cycle, launch the cycle after.
      req_data[0 +: DW] = 8'hA5;
      req_valid = 4'b0001;
      tick();
      check("t1_ready", 32'(req_ready), 32'h1);
      check("t1_dv_not_yet", 32'(tx_data_valid), 32'd0);
      req_valid = '0;
      tick();
      check("t1_dv", 32'(tx_data_valid), 32'd1);
      check("t1_data", 32'(tx_p_data), 32'hA5);
      check("t1_grant", 32'(grant_id), 32'd0);
      wait_idle(60);

      // All requesters continuously valid, fixed frame length.
      reset_pulse();
      grant_log.delete(); tx_log.delete();
      for (int i = 0; i < N; i++) req_data[i*DW +: DW] = DW'(8'h10 + i);
      frame_len = 11;
      run_frames(4'hF, 5);
      check("t2_frames", 32'(tx_log.size()), 32'd5);
      for (int i = 0; i < 5; i++) begin
         check("t2_grant_order", 32'(grant_log[i]), 32'(order2[i]));
         check("t2_tx_byte", 32'(tx_log[i]), 32'(8'h10 + order2[i]));
      end

      // Pointer wrap after requester 3.
      reset_pulse();
      grant_log.delete();
      run_frames(4'b1000, 1);
      run_frames(4'b1001, 2);
      for (int i = 0; i < 3; i++) check("t3_wrap_order", 32'(grant_log[i]), 32'(order3[i]));

      // Reset while waiting for the frame to finish; transmitter stays busy afterwards.
      reset_pulse();
      req_valid = 4'b0010;
      c = 0;
      while (!(tx_busy && arb_busy) && c < 20) begin tick(); c++; end
      check("t4_reached_frame", 32'(c < 20), 32'd1);
      req_valid = '0;
      tick();
      tx_force = 1'b1;
      RST = 1'b1;
      tick();
      check("t4_ready_after_rst", 32'(req_ready), 32'd0);
      check("t4_dv_after_rst", 32'(tx_data_valid), 32'd0);
      check("t4_busy_after_rst", 32'(arb_busy), 32'd0);
      check("t4_gid_after_rst", 32'(grant_id), 32'd0);
      check("t4_data_after_rst", 32'(tx_p_data), 32'd0);
      RST = 1'b0;
      req_valid = 4'b0110;
      pulses = 0;
      repeat (8) begin tick(); if (req_ready != '0) pulses++; end
      check("t5_no_ready_while_busy", 32'(pulses), 32'd0);
      tx_force = 1'b0;
      c = 0;
      while (req_ready == '0 && c < 30) begin tick(); c++; end
      check("t4_grant_from_ptr0", 32'(req_ready), 32'b0010);
      req_valid = '0;
      wait_idle(60);

      // Randomized traffic with occasional spurious busy and resets.
      reset_pulse();
      for (int i = 0; i < 600; i++) begin
         req_valid = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
         req_data  = (N*DW)'($urandom);
         frame_len = $urandom_range(1, 12);
         tx_force  = ($urandom_range(0, 40) == 0);
         RST       = ($urandom_range(0, 200) == 0);
         tick();
      end
      RST = 1'b0; tx_force = 1'b0; req_valid = '0;
      wait_idle(100);

`ifdef UART_TX_ARB_TIMEOUT_EN
      // Transmitter never acknowledges: flag after TO waiting cycles, pointer moves on.
      reset_pulse();
      grant_log.delete();
      tx_auto = 1'b0;
      req_valid = 4'b0001;
      c = 0;
      while (!tx_timeout && c < 60) begin tick(); c++; end
      req_valid = '0;
      check("t6_timeout_flag", 32'(tx_timeout), 32'd1);
      check("t6_timeout_latency", 32'(c), 32'(TO + 2));
      tx_auto = 1'b1;
      run_frames(4'b0011, 1);
      check("t6_next_grant", 32'(grant_log[1]), 32'd1);
      check("t6_flag_sticky", 32'(tx_timeout), 32'd1);
      reset_pulse();
      check("t6_flag_cleared", 32'(tx_timeout), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
